// File: rtl/apb_gpio_pkg.sv
// Shared types and constants for the APB requester that drives the GPIO slave.
package apb_gpio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Register map of the GPIO APB slave.
  localparam logic [31:0] GPIO_DIR = 32'd1;
  localparam logic [31:0] GPIO_IN  = 32'd2;
  localparam logic [31:0] GPIO_OUT = 32'd3;

  localparam int unsigned RSP_DATA_W = 32;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Wait-counter width; a zero TIMEOUT still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent with PREADY low and flags the edge that would reach TIMEOUT.
module apb_wait_timer
  import apb_gpio_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High on the enabled edge whose increment would make the count equal TIMEOUT.
  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired_o = 1'b0;
    end else begin : g_timeout
      assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_gpio_master.sv
// APB4 requester: turns each valid/ready command into one SETUP->ACCESS transfer
// and returns a single-cycle response with read data, error and timeout flags.
module apb_gpio_master
  import apb_gpio_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  // Command port: a command transfers on a PCLK edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE outside reset.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR,
  output apb_state_e          dbg_state
);

  apb_state_e            state_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]     paddr_q;
  logic [DATA_W-1:0]     pwdata_q;
  logic [DATA_W/8-1:0]   pstrb_q;
  logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic                  accept, wait_cycle, timer_expired;

  assign cmd_ready  = (state_q == IDLE) && !PRESET;
  assign accept     = cmd_valid && cmd_ready;
  assign wait_cycle = (state_q == ACCESS) && !PREADY;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .clr_i     (accept),
    .en_i      (wait_cycle),
    .expired_o (timer_expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            psel_q   <= 1'b1;
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            // Reads carry no strobes and leave PWDATA untouched.
            if (cmd_write) begin
              pwdata_q <= cmd_wdata;
              pstrb_q  <= cmd_strb;
            end else begin
              pstrb_q  <= '0;
            end
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave on the final wait edge takes priority over the abort.
          if (PREADY) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end else if (timer_expired) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_gpio_master.sv
// Directed bench for apb_gpio_master with a small GPIO register slave model.
module tb_apb_gpio_master;
  import apb_gpio_pkg::*;

  localparam int unsigned TIMEOUT = 16;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  apb_state_e  dbg_state;

  apb_gpio_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // Clock/reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave model: 4 word registers, programmable wait states, stuck and error modes.
  logic [31:0] mem [4];
  int          wait_n;
  int          acc_cnt;
  logic        stuck, slv_err, slave_clr;

  assign PREADY  = !stuck && (acc_cnt >= wait_n);
  assign PSLVERR = slv_err && PSELx && PENABLE;
  assign PRDATA  = mem[PADDR[1:0]];

  always @(posedge PCLK) begin
    if (PSELx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                             acc_cnt <= 0;
    if (slave_clr) begin
      mem[0] <= 32'h0;
      mem[1] <= 32'h0;
      mem[2] <= 32'h5A5A_1234;
      mem[3] <= 32'h0;
    end else if (PSELx && PENABLE && PREADY && PWRITE) begin
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) mem[PADDR[1:0]][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

  // Scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pwdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_n;
    logic        stuck;
    logic        err;
    apb_rsp_t    exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check_apb_hold(input vec_t v, input string ph);
    check({ph, "_pwrite"}, 32'(PWRITE), 32'(v.write));
    check({ph, "_paddr"},  PADDR, v.addr);
    check({ph, "_pstrb"},  32'(PSTRB), v.write ? 32'(v.strb) : 32'h0);
    check({ph, "_pwdata"}, PWDATA, exp_pwdata);
    check({ph, "_cmd_ready"}, 32'(cmd_ready), 32'h0);
  endtask

  // Driver: issue one command at a negedge and follow it to its response.
  task automatic run_vec(input vec_t v);
    int   acc;
    bit   got;
    int   exp_acc;
    logic [31:0] hold_rdata;
    exp_acc = v.stuck ? int'(TIMEOUT) : v.wait_n + 1;
    wait_n  = v.wait_n;
    stuck   = v.stuck;
    slv_err = v.err;
    if (v.write) exp_pwdata = v.wdata;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    check("idle_cmd_ready", 32'(cmd_ready), 32'h1);
    exp_q.push_back(v.exp.rdata);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'hDEAD_BEEF;
    cmd_strb  = 4'hF;
    check("setup_sel_en", {30'h0, PSELx, PENABLE}, 32'h2);
    check_apb_hold(v, "setup");
    acc = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        acc++;
        check("access_sel_en", {30'h0, PSELx, PENABLE}, 32'h3);
        check_apb_hold(v, "access");
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got no rsp_valid within 40 cycles, expected one");
      void'(exp_q.pop_front());
    end else begin
      check("access_cycles", 32'(acc), 32'(exp_acc));
      check("rsp_rdata", rsp_rdata, exp_q.pop_front());
      check("rsp_err", 32'(rsp_err), 32'(v.exp.err));
      check("rsp_timeout", 32'(rsp_timeout), 32'(v.exp.timeout));
      check("rsp_cmd_ready", 32'(cmd_ready), 32'h1);
      check("rsp_sel_en", {30'h0, PSELx, PENABLE}, 32'h0);
      hold_rdata = v.exp.rdata;
      @(negedge PCLK);
      check("rsp_pulse", 32'(rsp_valid), 32'h0);
      check("rsp_rdata_hold", rsp_rdata, hold_rdata);
      check("rsp_err_hold", 32'(rsp_err), 32'(v.exp.err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, GPIO_DIR, 32'hFFFF_FFFF, 4'hF, 0,  1'b0, 1'b0, '{32'h0,          1'b0, 1'b0}};
    vecs[1]  = '{1'b0, GPIO_DIR, 32'h0,         4'hF, 0,  1'b0, 1'b0, '{32'hFFFF_FFFF,  1'b0, 1'b0}};
    vecs[2]  = '{1'b1, GPIO_OUT, 32'hF00F_F0FF, 4'h1, 3,  1'b0, 1'b0, '{32'h0,          1'b0, 1'b0}};
    vecs[3]  = '{1'b0, GPIO_OUT, 32'h0,         4'h0, 0,  1'b0, 1'b0, '{32'h0000_00FF,  1'b0, 1'b0}};
    vecs[4]  = '{1'b0, GPIO_IN,  32'h0,         4'h0, 0,  1'b0, 1'b1, '{32'h5A5A_1234,  1'b1, 1'b0}};
    vecs[5]  = '{1'b0, GPIO_DIR, 32'h0,         4'h0, 0,  1'b1, 1'b0, '{32'h0,          1'b1, 1'b1}};
    vecs[6]  = '{1'b0, GPIO_DIR, 32'h0,         4'h0, 0,  1'b0, 1'b0, '{32'hFFFF_FFFF,  1'b0, 1'b0}};
    vecs[7]  = '{1'b0, GPIO_DIR, 32'h0,         4'h0, 15, 1'b0, 1'b0, '{32'hFFFF_FFFF,  1'b0, 1'b0}};
    vecs[8]  = '{1'b1, 32'd0,    32'h1234_5678, 4'hC, 2,  1'b0, 1'b0, '{32'h0,          1'b0, 1'b0}};
    vecs[9]  = '{1'b0, 32'd0,    32'h0,         4'h0, 1,  1'b0, 1'b0, '{32'h1234_0000,  1'b0, 1'b0}};
    vecs[10] = '{1'b1, GPIO_OUT, 32'hAABB_CCDD, 4'h0, 0,  1'b0, 1'b1, '{32'h0,          1'b1, 1'b0}};
    vecs[11] = '{1'b0, GPIO_OUT, 32'h0,         4'h0, 0,  1'b0, 1'b0, '{32'h0000_00FF,  1'b0, 1'b0}};

    PRESET = 1'b1; slave_clr = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    wait_n = 0; stuck = 1'b0; slv_err = 1'b0; exp_pwdata = '0;
    repeat (8) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_cmd_ready", 32'(cmd_ready), 32'h0);
    check("reset_sel_en", {30'h0, PSELx, PENABLE}, 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_paddr", PADDR, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    PRESET = 1'b0; slave_clr = 1'b0;
    @(negedge PCLK);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'h1);
    check("post_reset_state", 32'(dbg_state), 32'(IDLE));

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset while a transfer sits in ACCESS with a hung slave.
    stuck = 1'b1; slv_err = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = GPIO_OUT;
    cmd_wdata = 32'h1111_1111; cmd_strb = 4'hF;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("rst_mid_in_access", 32'(dbg_state), 32'(ACCESS));
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rst_mid_sel_en", {30'h0, PSELx, PENABLE}, 32'h0);
    check("rst_mid_pwrite", 32'(PWRITE), 32'h0);
    check("rst_mid_paddr", PADDR, 32'h0);
    check("rst_mid_pwdata", PWDATA, 32'h0);
    check("rst_mid_pstrb", 32'(PSTRB), 32'h0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mid_rsp_err", {30'h0, rsp_err, rsp_timeout}, 32'h0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'h0);
    PRESET = 1'b0; stuck = 1'b0; exp_pwdata = 32'h0;
    @(negedge PCLK);
    check("rst_release_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_release_no_rsp", 32'(rsp_valid), 32'h0);
    run_vec(vecs[11]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_gpio_master.md
Name: apb_gpio_master

Overview:
APB4 requester that drives the GPIO APB slave (top_GPIO_APBSlave) from a simple valid/ready command port.
- Converts each accepted command into one APB SETUP→ACCESS transfer.
- Honours PREADY wait states, captures PRDATA and PSLVERR, and returns a one-cycle response.
- A bounded-wait timeout aborts transfers to a hung slave.
- Sits between an on-chip controller or sequencer and the GPIO slave, replacing bench-driven APB stimulus.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width; PSTRB width is DATA_W/8
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock
PRESET  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Interface: one clock PCLK; PRESET is synchronous and active-high.
- Reset: sampled at a PCLK edge with PRESET=1.
  - All outputs go to 0, including rsp_rdata and PADDR/PWDATA/PSTRB; state goes to IDLE; timeout counter clears.
  - cmd_ready is 0 while PRESET=1.
  - A transfer in flight is dropped with no rsp_valid.
- State machine: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1 and PSELx=0.
  - On a cmd_valid&cmd_ready edge: register PWRITE, PADDR, PWDATA and PSTRB, then go to SETUP.
  - For reads, PSTRB is forced to 0 and PWDATA holds its previous value.
- SETUP (exactly one cycle): PSELx=1, PENABLE=0, cmd_ready=0; unconditionally → ACCESS.
- ACCESS: PSELx=1, PENABLE=1; PADDR, PWRITE, PWDATA and PSTRB stay stable.
  - Edge with PREADY=1 → IDLE.
    - Next cycle: PSELx=0, PENABLE=0, rsp_valid=1.
    - rsp_rdata = PRDATA sampled on that edge for a read, 0 for a write.
    - rsp_err = PSLVERR sampled on that edge; rsp_timeout=0.
  - Edge with PREADY=0: the wait counter increments.
  - Counter reaches TIMEOUT (TIMEOUT>0) while PREADY is still 0 → IDLE.
    - rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same edge the counter would hit TIMEOUT: completion wins and no timeout is reported.
- Latency:
  - Command accepted at edge N; SETUP occupies cycle N..N+1; ACCESS starts at edge N+1.
  - With zero wait states, the transfer completes at edge N+2 and rsp_valid is high in cycle N+2..N+3.
  - Each wait state adds 1 cycle. Minimum command-to-command spacing is 3 cycles.
- Pulse and ordering rules:
  - rsp_valid is a single-cycle pulse; rsp_rdata, rsp_err and rsp_timeout hold until the next response.
  - cmd_ready returns to 1 in the same cycle rsp_valid is high. A new command may be accepted at that edge.
  - No back-to-back SETUP is issued without returning to IDLE.
- Input sampling: PREADY, PSLVERR and PRDATA are ignored outside ACCESS. cmd_* inputs are ignored unless accepted.
- Counter width: $clog2(TIMEOUT+1), clamped to a minimum of 1; it is cleared on entry to SETUP.

Decomposition:
- Package apb_gpio_pkg:
  - State enum: IDLE, SETUP, ACCESS.
  - GPIO register address constants: GPIO_DIR=1, GPIO_IN=2, GPIO_OUT=3.
  - Response struct {rdata, err, timeout}.
- One sub-module, apb_wait_timer: counter with clear, enable and expired output, parameterised by TIMEOUT.

Test Plan:
- Reset 8 cycles, then write addr 1 data FFFF_FFFF strb 1111 with PREADY tied 1. Required: PSELx=1/PENABLE=0 for one cycle, then PENABLE=1 for one cycle. Next cycle rsp_valid=1, rsp_err=0. cmd_ready is low for exactly 2 cycles.
- Read addr 1 after the write above (slave attached). Required: PSTRB=0000, PWRITE=0, rsp_rdata=FFFF_FFFF.
- Write addr 3 data F00F_F0FF strb 0001 with PREADY held low 3 cycles. Required: ACCESS lasts 4 cycles with PADDR/PWDATA/PSTRB stable, and rsp_valid arrives 3 cycles later than in the zero-wait case.
- Read addr 2 with PSLVERR=1 and PREADY=1 in ACCESS. Required: rsp_err=1, rsp_timeout=0, rsp_rdata=captured PRDATA.
- TIMEOUT=16 with PREADY stuck 0. Required: after 16 ACCESS cycles, PSELx/PENABLE drop, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. The next command proceeds normally.
- Assert PRESET during ACCESS. Required: at the next edge all APB outputs are 0, no rsp_valid is seen, and cmd_ready=1 the cycle after PRESET deasserts.
